// File: rtl/sdr_wr_feeder_if.sv
// Bundle of the stream-in and SDRAM-write-side signals of sdr_wr_feeder.
//   slave  : feeder view (accepts the word stream, drives the SDRAM write side)
//   master : environment view (produces words, consumes bursts)
//   in_data/in_valid/in_ready/in_flush           : upstream word stream and flush pulse
//   sdr_wr_req/sdr_waddr/sdr_wr_byte_cnt          : burst request with start address and beats
//   sdr_wdata_in/sdr_wdata_wr/sdr_wr_ready        : per-word data, strobe and back-pressure
//   busy/burst_done/fifo_level                    : status
interface sdr_wr_feeder_if #(
    parameter int unsigned FIFO_DEPTH = 512
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_flush;
    logic          sdr_wr_req;
    logic [31:0]   sdr_waddr;
    logic [11:0]   sdr_wr_byte_cnt;
    logic [15:0]   sdr_wdata_in;
    logic          sdr_wdata_wr;
    logic          sdr_wr_ready;
    logic          busy;
    logic          burst_done;
    logic [LW-1:0] fifo_level;

    modport slave (
        input  in_data, in_valid, in_flush, sdr_wr_ready,
        output in_ready, sdr_wr_req, sdr_waddr, sdr_wr_byte_cnt,
               sdr_wdata_in, sdr_wdata_wr, busy, burst_done, fifo_level
    );

    modport master (
        output in_data, in_valid, in_flush, sdr_wr_ready,
        input  in_ready, sdr_wr_req, sdr_waddr, sdr_wr_byte_cnt,
               sdr_wdata_in, sdr_wdata_wr, busy, burst_done, fifo_level
    );
endinterface

// File: rtl/sdr_wr_feeder.sv
// Write-side feeder for sdr_top: buffers a 16-bit word stream in a FIFO, slices it
// into bursts of up to BURST_WORDS beats, issues one request per burst and paces the
// words out at most one every other cycle, walking a circular SDRAM address region.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : sdr_wr_feeder_if.slave (stream in, SDRAM write side, status)
module sdr_wr_feeder #(
    parameter int unsigned FIFO_DEPTH  = 512,
    parameter int unsigned BURST_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [31:0] ADDR_LIMIT  = 32'h0010_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    sdr_wr_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = 12;
    localparam int unsigned DW = 16;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] BURST_L = LW'(BURST_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_GAP
    } state_e;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          in_ready_q;
    logic          flush_q;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] rem_q;
    logic [31:0]   waddr_q;
    logic          wr_req_q;
    logic [DW-1:0] wdata_q;
    logic          wdata_wr_q;
    logic          busy_q;
    logic          burst_done_q;

    logic          push_c;
    logic          pop_c;
    logic          launch_c;
    logic [CW-1:0] launch_cnt_c;
    logic [32:0]   waddr_sum_c;
    logic [31:0]   waddr_next_c;

    assign push_c = bus.in_valid & in_ready_q;
    assign pop_c  = (state_q == S_XFER) & bus.sdr_wr_ready;

    // A burst starts on a full slice, or on any leftover words once a flush is pending.
    assign launch_c     = (level_q >= BURST_L) || (flush_q && (level_q != '0));
    assign launch_cnt_c = (level_q >= BURST_L) ? CW'(BURST_WORDS) : CW'(level_q);

    // Next burst start address, wrapping to the region base at the limit.
    assign waddr_sum_c  = {1'b0, waddr_q} + 33'(cnt_q);
    assign waddr_next_c = (waddr_sum_c >= {1'b0, ADDR_LIMIT}) ? BASE_ADDR : waddr_sum_c[31:0];

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        level_d = level_q;
        if (push_c && !pop_c) begin
            level_d = level_q + LW'(1);
        end else if (pop_c && !push_c) begin
            level_d = level_q - LW'(1);
        end
    end

    // FIFO storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    // FIFO pointers and level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            in_ready_q <= (level_d < DEPTH_L);
        end
    end

    // Burst FSM with registered request, strobe, status and flush latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            flush_q      <= 1'b0;
            cnt_q        <= '0;
            rem_q        <= '0;
            waddr_q      <= BASE_ADDR;
            wr_req_q     <= 1'b0;
            wdata_q      <= '0;
            wdata_wr_q   <= 1'b0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            wr_req_q     <= 1'b0;
            wdata_wr_q   <= 1'b0;
            burst_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (launch_c) begin
                        state_q  <= S_REQ;
                        cnt_q    <= launch_cnt_c;
                        rem_q    <= launch_cnt_c;
                        wr_req_q <= 1'b1;
                        busy_q   <= 1'b1;
                        // This burst drains everything buffered, so the flush is served.
                        if (level_q <= BURST_L) begin
                            flush_q <= 1'b0;
                        end
                    end else if (level_q == '0) begin
                        flush_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    state_q <= S_XFER;
                end
                S_XFER: begin
                    if (bus.sdr_wr_ready) begin
                        wdata_wr_q <= 1'b1;
                        wdata_q    <= mem[rd_ptr_q];
                        rem_q      <= rem_q - CW'(1);
                        state_q    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (rem_q != '0) begin
                        state_q <= S_XFER;
                    end else begin
                        state_q      <= S_IDLE;
                        burst_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        waddr_q      <= waddr_next_c;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A new flush request always wins over a same-cycle clear.
            if (bus.in_flush) begin
                flush_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.sdr_wr_req      = wr_req_q;
    assign bus.sdr_waddr       = waddr_q;
    assign bus.sdr_wr_byte_cnt = cnt_q;
    assign bus.sdr_wdata_in    = wdata_q;
    assign bus.sdr_wdata_wr    = wdata_wr_q;
    assign bus.busy            = busy_q;
    assign bus.burst_done      = burst_done_q;
    assign bus.fifo_level      = level_q;

endmodule

// File: tb/tb_sdr_wr_feeder.sv
// Self-checking bench for sdr_wr_feeder: a table of push/flush scenarios with
// hand-computed burst counts, addresses and final state, plus directed sequences
// for back-pressure, address wrap and reset mid-burst.
module tb_sdr_wr_feeder;

    logic clk;
    logic rst_n;

    sdr_wr_feeder_if #(.FIFO_DEPTH(512)) bus ();
    sdr_wr_feeder_if #(.FIFO_DEPTH(512)) wbus ();

    sdr_wr_feeder #(
        .FIFO_DEPTH (512),
        .BURST_WORDS(256),
        .BASE_ADDR  (32'h0),
        .ADDR_LIMIT (32'h0010_0000)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    sdr_wr_feeder #(
        .FIFO_DEPTH (512),
        .BURST_WORDS(256),
        .BASE_ADDR  (32'h0),
        .ADDR_LIMIT (32'd512)
    ) u_wrap (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- monitors (sole writers of their variables) ----------------
    logic [15:0] got_data[$];
    logic [31:0] got_addr[$];
    logic [11:0] got_cnt[$];
    int  done_cnt      = 0;
    int  b2b_cnt       = 0;
    int  ready_bad     = 0;
    int  full_cnt      = 0;
    int  stall_strobes = 0;
    bit  prev_wr       = 1'b0;
    bit  stall_win     = 1'b0;
    logic [31:0] w_addr[$];
    int  w_words       = 0;

    always @(negedge clk) begin
        if (bus.sdr_wdata_wr) begin
            got_data.push_back(bus.sdr_wdata_in);
            if (prev_wr) b2b_cnt++;
            if (stall_win) stall_strobes++;
        end
        prev_wr = bus.sdr_wdata_wr;
        if (bus.sdr_wr_req) begin
            got_addr.push_back(bus.sdr_waddr);
            got_cnt.push_back(bus.sdr_wr_byte_cnt);
        end
        if (bus.burst_done) done_cnt++;
        if (bus.in_ready !== (bus.fifo_level < 10'd512)) ready_bad++;
        if (bus.fifo_level == 10'd512) full_cnt++;
        if (wbus.sdr_wr_req) w_addr.push_back(wbus.sdr_waddr);
        if (wbus.sdr_wdata_wr) w_words++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.in_flush = 1'b0;  bus.in_data = '0;  bus.sdr_wr_ready = 1'b1;
        wbus.in_valid = 1'b0; wbus.in_flush = 1'b0; wbus.in_data = '0; wbus.sdr_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push_word(input bit sel, input logic [15:0] w, output bit ok);
        bit acc;
        ok = 1'b0;
        if (sel) begin wbus.in_valid = 1'b1; wbus.in_data = w; end
        else     begin bus.in_valid  = 1'b1; bus.in_data  = w; end
        for (int t = 0; t < 4000 && !ok; t++) begin
            @(negedge clk);
            acc = sel ? wbus.in_ready : bus.in_ready;
            @(posedge clk); #1;
            if (acc) ok = 1'b1;
        end
        bus.in_valid  = 1'b0;
        wbus.in_valid = 1'b0;
    endtask

    task automatic push_seq(input bit sel, input int base, input int n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n && ok; i++) push_word(sel, 16'(base + i), ok);
    endtask

    task automatic pulse_flush(input bit sel);
        if (sel) wbus.in_flush = 1'b1; else bus.in_flush = 1'b1;
        @(posedge clk); #1;
        bus.in_flush  = 1'b0;
        wbus.in_flush = 1'b0;
    endtask

    task automatic wait_drain(input int target, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40000 && !ok; t++) begin
            @(negedge clk); #1;
            if (got_data.size() >= target) ok = 1'b1;
        end
        for (int t = 0; t < 100 && bus.busy; t++) @(negedge clk);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int n;
        bit flush;
        bit flush2;
        int exp_reqs;
        int exp_last;
        int exp_level;
        int exp_addr;
    } vec_t;

    localparam int NROWS = 7;
    vec_t tbl[NROWS];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        int d0, a0, b0, mism, f0, s0, sn;

        tbl[0] = '{256,  1'b0, 1'b0, 1, 256, 0,   256};
        tbl[1] = '{1000, 1'b1, 1'b0, 4, 232, 0,   1000};
        tbl[2] = '{10,   1'b1, 1'b1, 1, 10,  0,   10};
        tbl[3] = '{300,  1'b1, 1'b0, 2, 44,  0,   300};
        tbl[4] = '{1,    1'b1, 1'b0, 1, 1,   0,   1};
        tbl[5] = '{255,  1'b0, 1'b0, 0, 0,   255, 0};
        tbl[6] = '{512,  1'b0, 1'b0, 2, 256, 0,   512};

        rst_n = 1'b0;
        do_reset();

        // Reset state.
        check("rst_in_ready",   bus.in_ready,        1);
        check("rst_wr_req",     bus.sdr_wr_req,      0);
        check("rst_waddr",      bus.sdr_waddr,       0);
        check("rst_byte_cnt",   bus.sdr_wr_byte_cnt, 0);
        check("rst_wdata_wr",   bus.sdr_wdata_wr,    0);
        check("rst_wdata_in",   bus.sdr_wdata_in,    0);
        check("rst_busy",       bus.busy,            0);
        check("rst_burst_done", bus.burst_done,      0);
        check("rst_fifo_level", bus.fifo_level,      0);

        // Table-driven push/flush scenarios, each from a fresh reset.
        for (int r = 0; r < NROWS; r++) begin
            do_reset();
            d0 = got_data.size(); a0 = got_addr.size(); b0 = done_cnt;
            push_seq(1'b0, r * 1024, tbl[r].n, ok);
            check($sformatf("row%0d_push_accepted", r), ok, 1);
            if (tbl[r].flush) pulse_flush(1'b0);
            wait_drain(d0 + tbl[r].exp_addr, ok);
            check($sformatf("row%0d_drain", r), ok, 1);
            if (tbl[r].flush2) pulse_flush(1'b0);
            repeat (20) @(posedge clk);
            #1;
            check($sformatf("row%0d_reqs", r), got_addr.size() - a0, tbl[r].exp_reqs);
            for (int k = 0; k < tbl[r].exp_reqs && (a0 + k) < got_addr.size(); k++) begin
                check($sformatf("row%0d_req%0d_addr", r, k), got_addr[a0 + k], 256 * k);
                check($sformatf("row%0d_req%0d_cnt", r, k), got_cnt[a0 + k],
                      (k == tbl[r].exp_reqs - 1) ? tbl[r].exp_last : 256);
            end
            check($sformatf("row%0d_words", r), got_data.size() - d0, tbl[r].exp_addr);
            mism = 0;
            for (int i = 0; i < tbl[r].exp_addr && (d0 + i) < got_data.size(); i++)
                if (got_data[d0 + i] != 16'(r * 1024 + i)) mism++;
            check($sformatf("row%0d_data_mismatches", r), mism, 0);
            check($sformatf("row%0d_burst_done", r), done_cnt - b0, tbl[r].exp_reqs);
            check($sformatf("row%0d_waddr", r), bus.sdr_waddr, tbl[r].exp_addr);
            check($sformatf("row%0d_fifo_level", r), bus.fifo_level, tbl[r].exp_level);
            check($sformatf("row%0d_busy", r), bus.busy, 0);
        end

        // Back-pressure: stall sdr_wr_ready for 50 cycles while pushing nonstop.
        do_reset();
        d0 = got_data.size(); f0 = full_cnt; s0 = stall_strobes;
        fork
            begin
                push_seq(1'b0, 16'h8000, 1000, ok);
                check("stall_push_accepted", ok, 1);
            end
            begin
                bit reached;
                reached = 1'b0;
                for (int t = 0; t < 5000 && !reached; t++) begin
                    @(negedge clk);
                    if (bus.fifo_level >= 10'd470) reached = 1'b1;
                end
                check("stall_level_reached", reached, 1);
                @(posedge clk); #1;
                bus.sdr_wr_ready = 1'b0;
                @(posedge clk); #1;
                stall_win = 1'b1;
                repeat (49) @(posedge clk);
                #1;
                stall_win = 1'b0;
                bus.sdr_wr_ready = 1'b1;
            end
        join
        pulse_flush(1'b0);
        wait_drain(d0 + 1000, ok);
        check("stall_drain", ok, 1);
        check("stall_no_strobes", stall_strobes - s0, 0);
        check("stall_fifo_reached_full", (full_cnt > f0) ? 1 : 0, 1);
        check("stall_words", got_data.size() - d0, 1000);
        mism = 0;
        for (int i = 0; i < 1000 && (d0 + i) < got_data.size(); i++)
            if (got_data[d0 + i] != 16'(16'h8000 + i)) mism++;
        check("stall_data_mismatches", mism, 0);
        check("stall_fifo_level", bus.fifo_level, 0);

        // Address wrap on the 512-word region.
        do_reset();
        a0 = w_addr.size(); s0 = w_words;
        push_seq(1'b1, 0, 768, ok);
        check("wrap_push_accepted", ok, 1);
        ok = 1'b0;
        for (int t = 0; t < 20000 && !ok; t++) begin
            @(negedge clk); #1;
            if (w_words - s0 >= 768) ok = 1'b1;
        end
        check("wrap_drain", ok, 1);
        repeat (10) @(posedge clk);
        #1;
        check("wrap_reqs", w_addr.size() - a0, 3);
        if (w_addr.size() - a0 >= 3) begin
            check("wrap_addr0", w_addr[a0],     0);
            check("wrap_addr1", w_addr[a0 + 1], 256);
            check("wrap_addr2", w_addr[a0 + 2], 0);
        end
        check("wrap_waddr_final", wbus.sdr_waddr, 256);

        // Reset asserted after 100 beats of a 256-beat burst.
        do_reset();
        s0 = got_data.size();
        push_seq(1'b0, 16'h4000, 256, ok);
        check("rstmid_push_accepted", ok, 1);
        ok = 1'b0;
        for (int t = 0; t < 5000 && !ok; t++) begin
            @(negedge clk); #2;
            if (got_data.size() >= s0 + 100) ok = 1'b1;
        end
        check("rstmid_reached_100", ok, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_strobe_low", bus.sdr_wdata_wr, 0);
        check("rstmid_busy_low",   bus.busy,         0);
        sn = got_data.size();
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rstmid_no_strobes", got_data.size() - sn, 0);
        check("rstmid_fifo_level", bus.fifo_level, 0);
        check("rstmid_waddr",      bus.sdr_waddr,  0);
        check("rstmid_busy",       bus.busy,       0);
        check("rstmid_in_ready",   bus.in_ready,   1);
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_stays_empty", bus.fifo_level, 0);
        check("rstmid_no_request",  bus.busy,       0);

        // Global properties collected by the monitor.
        check("no_back_to_back_strobes", b2b_cnt,   0);
        check("in_ready_tracks_level",   ready_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
